// File: rtl/set_assoc_cache_ctrl_if.sv
// Bus bundle between the pipeline/memory side and the cache tag/LRU controller.
// The controller takes the slave view; the pipeline and memory take the master view.
interface set_assoc_cache_ctrl_if #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_SETS    = 64,
    parameter int unsigned BLOCK_WORDS = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WRD_W = $clog2(BLOCK_WORDS);

    // Lookup side
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              hit;
    logic              hit_way;
    logic              stall;

    // Main memory side
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data_in;

    // Data array fill side
    logic              fill_we;
    logic              fill_way;
    logic [IDX_W-1:0]  fill_set;
    logic [WRD_W-1:0]  fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              fill_done;

    modport slave (
        input  req_valid, req_addr, flush, mem_data_valid, mem_data_in,
        output hit, hit_way, stall, mem_req, mem_addr,
        output fill_we, fill_way, fill_set, fill_word, fill_data, fill_done
    );

    modport master (
        output req_valid, req_addr, flush, mem_data_valid, mem_data_in,
        input  hit, hit_way, stall, mem_req, mem_addr,
        input  fill_we, fill_way, fill_set, fill_word, fill_data, fill_done
    );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative cache tag/LRU controller with a miss-fill FSM.
// Tags, valid bits and per-set LRU live in flops; the data array is external and is
// written word by word through the fill_* outputs while a block streams in from memory.
module set_assoc_cache_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_SETS    = 64,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input logic                   clk,
    input logic                   rst,
    set_assoc_cache_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WRD_W = $clog2(BLOCK_WORDS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - WRD_W - 1;
    localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    // State
    state_e            state_q, state_d;
    logic [NUM_SETS-1:0] valid_q [2];
    logic [NUM_SETS-1:0] valid_d [2];
    logic [TAG_W-1:0]  tag_q [2][NUM_SETS];
    logic [TAG_W-1:0]  tag_d [2][NUM_SETS];
    // lru bit = way to evict next
    logic [NUM_SETS-1:0] lru_q, lru_d;

    // Miss context latched on IDLE->FILL
    logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic              victim_q, victim_d;
    logic [WRD_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [WRD_W-1:0]  ret_cnt_q, ret_cnt_d;
    // Set once all BLOCK_WORDS reads are issued; the issue counter wraps so it cannot tell
    logic              issue_done_q, issue_done_d;

    // Lookup
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              hit0, hit1;
    logic              is_idle;
    logic              lookup_hit;
    logic              lookup_way;
    logic              victim_sel;
    logic              mem_req_int;
    logic              fill_we_int;

    // Byte and word offset do not take part in tag matching.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[WRD_W:0];

    assign req_tag = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = bus.req_addr[WRD_W+1 +: IDX_W];

    // Tag compare, hit resolution and victim choice for the current request.
    always_comb begin
        hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
        hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
        is_idle    = (state_q == StIdle);
        lookup_hit = bus.req_valid && is_idle && (hit0 || hit1);
        lookup_way = lookup_hit && hit1 && !hit0;
        if (!valid_q[0][req_idx]) begin
            victim_sel = 1'b0;
        end else if (!valid_q[1][req_idx]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru_q[req_idx];
        end
        mem_req_int = (state_q == StFill) && !issue_done_q;
        fill_we_int = (state_q == StFill) && bus.mem_data_valid;
    end

    // Next-state for the FSM, tag/valid/LRU arrays and fill counters.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        lru_d        = lru_q;
        fill_tag_d   = fill_tag_q;
        fill_idx_d   = fill_idx_q;
        victim_d     = victim_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        issue_done_d = issue_done_q;

        case (state_q)
            StIdle: begin
                if (bus.flush) begin
                    // Flush wins over a same-cycle hit: no LRU update, no fill start.
                    valid_d[0] = '0;
                    valid_d[1] = '0;
                end else if (lookup_hit) begin
                    lru_d[req_idx] = ~lookup_way;
                end else if (bus.req_valid) begin
                    state_d      = StFill;
                    fill_tag_d   = req_tag;
                    fill_idx_d   = req_idx;
                    victim_d     = victim_sel;
                    issue_cnt_d  = '0;
                    ret_cnt_d    = '0;
                    issue_done_d = 1'b0;
                end
            end

            StFill: begin
                if (!issue_done_q) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_WORD) begin
                        issue_done_d = 1'b1;
                    end
                end
                if (bus.mem_data_valid) begin
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == LAST_WORD) begin
                        // Block becomes visible only once its final word is written.
                        tag_d[victim_q][fill_idx_q]   = fill_tag_q;
                        valid_d[victim_q][fill_idx_q] = 1'b1;
                        lru_d[fill_idx_q]             = ~victim_q;
                        state_d                       = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset also discards any partially filled block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            lru_q        <= '0;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
            victim_q     <= 1'b0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            issue_done_q <= 1'b0;
            for (int w = 0; w < 2; w++) begin
                valid_q[w] <= '0;
                for (int s = 0; s < NUM_SETS; s++) begin
                    tag_q[w][s] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            lru_q        <= lru_d;
            fill_tag_q   <= fill_tag_d;
            fill_idx_q   <= fill_idx_d;
            victim_q     <= victim_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            issue_done_q <= issue_done_d;
        end
    end

    // Output drive; mem_addr is held at zero whenever no read is being issued.
    always_comb begin
        bus.hit       = lookup_hit;
        bus.hit_way   = lookup_way;
        bus.stall     = (bus.req_valid && is_idle && !lookup_hit) || !is_idle;
        bus.mem_req   = mem_req_int;
        bus.mem_addr  = '0;
        if (mem_req_int) begin
            bus.mem_addr = {fill_tag_q, fill_idx_q, issue_cnt_q, 1'b0};
        end
        bus.fill_we   = fill_we_int;
        bus.fill_way  = victim_q;
        bus.fill_set  = fill_idx_q;
        bus.fill_word = ret_cnt_q;
        bus.fill_data = bus.mem_data_in;
        bus.fill_done = (state_q == StDone);
    end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench for set_assoc_cache_ctrl: directed table of accesses, hand-written
// flush/stray/reset-abort sequences, then random accesses against a set/way array model.
module tb_set_assoc_cache_ctrl;
    localparam int NSETS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    set_assoc_cache_ctrl_if bus ();

    set_assoc_cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per set/way valid+tag, per set the way to evict next.
    bit       m_valid [2][NSETS];
    bit [5:0] m_tag   [2][NSETS];
    bit       m_lru   [NSETS];

    typedef struct {
        logic [15:0] addr;
        bit          exp_hit;
        bit          exp_way;  // hit way, or victim way on a miss
        int          lat;
        bit          gap;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic model_clear_valid();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < NSETS; s++) m_valid[w][s] = 1'b0;
    endtask

    function automatic void predict(input logic [15:0] a, output bit h, output bit w);
        int       s;
        bit [5:0] t;
        s = int'(a[9:4]);
        t = a[15:10];
        if (m_valid[0][s] && m_tag[0][s] == t) begin
            h = 1'b1; w = 1'b0;
        end else if (m_valid[1][s] && m_tag[1][s] == t) begin
            h = 1'b1; w = 1'b1;
        end else begin
            h = 1'b0;
            if (!m_valid[0][s])      w = 1'b0;
            else if (!m_valid[1][s]) w = 1'b1;
            else                     w = m_lru[s];
        end
    endfunction

    // Starts just after a negedge. On a miss plays memory with the given latency/gaps;
    // abort_n > 0 asserts reset after that many returns.
    task automatic access(input logic [15:0] a, input bit exp_hit, input bit exp_way,
                          input int lat, input bit gap, input int abort_n);
        int          s;
        logic [15:0] base;
        logic [15:0] ea;
        int          issued;
        int          returned;
        int          cyc;
        int          ready_q[$];
        bit          drove;
        s        = int'(a[9:4]);
        base     = {a[15:4], 4'b0000};
        issued   = 0;
        returned = 0;
        cyc      = 0;

        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        #1;
        check("hit", bus.hit, exp_hit);
        check("hit_way", bus.hit_way, exp_hit ? exp_way : 1'b0);
        check("stall", bus.stall, !exp_hit);
        @(negedge clk);
        if (exp_hit) begin
            m_lru[s] = !exp_way;
            bus.req_valid = 1'b0;
            return;
        end

        while (returned < 8 && cyc < 200) begin
            drove = (ready_q.size() > 0) && (ready_q[0] <= cyc) && (!gap || (cyc % 2 == 0));
            bus.mem_data_valid = drove;
            ea = base + 16'(2 * returned);
            bus.mem_data_in = drove ? data_of(ea) : 16'h0000;
            #1;
            check("fill_stall", bus.stall, 1'b1);
            check("fill_done_early", bus.fill_done, 1'b0);
            check("fill_we", bus.fill_we, drove);
            if (drove) begin
                check("fill_word", bus.fill_word, returned);
                check("fill_way", bus.fill_way, exp_way);
                check("fill_set", bus.fill_set, s);
                check("fill_data", bus.fill_data, data_of(ea));
                void'(ready_q.pop_front());
                returned++;
            end
            if (issued < 8) begin
                ea = base + 16'(2 * issued);
                check("mem_req", bus.mem_req, 1'b1);
                check("mem_addr", bus.mem_addr, ea);
                ready_q.push_back(cyc + lat);
                issued++;
            end else begin
                check("mem_req_after_block", bus.mem_req, 1'b0);
            end
            cyc++;
            if (abort_n > 0 && returned == abort_n) begin
                @(negedge clk);
                rst = 1'b1;
                bus.req_valid      = 1'b0;
                bus.mem_data_valid = 1'b1;
                #1;
                check("abort_hit", bus.hit, 1'b0);
                check("abort_stall", bus.stall, 1'b0);
                check("abort_mem_req", bus.mem_req, 1'b0);
                check("abort_mem_addr", bus.mem_addr, 16'h0000);
                check("abort_fill_we", bus.fill_we, 1'b0);
                check("abort_fill_done", bus.fill_done, 1'b0);
                check("abort_fill_word", bus.fill_word, 0);
                @(negedge clk);
                rst = 1'b0;
                bus.mem_data_valid = 1'b0;
                model_clear_valid();
                for (int i = 0; i < NSETS; i++) m_lru[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (returned < 8) check("fill_timeout_returns", returned, 8);

        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = 16'h0000;
        #1;
        check("fill_done", bus.fill_done, 1'b1);
        check("done_stall", bus.stall, 1'b1);
        check("done_hit", bus.hit, 1'b0);
        check("done_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        #1;
        check("replay_hit", bus.hit, 1'b1);
        check("replay_hit_way", bus.hit_way, exp_way);
        check("replay_stall", bus.stall, 1'b0);
        check("replay_fill_done", bus.fill_done, 1'b0);
        m_valid[exp_way][s] = 1'b1;
        m_tag[exp_way][s]   = a[15:10];
        m_lru[s]            = !exp_way;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bit          h;
        bit          w;
        logic [15:0] a;
        logic [15:0] prior [3];
        int          sel;

        // addr, expected hit, expected hit way / victim way, memory latency, gapped returns
        tbl[0] = '{16'h1234, 1'b0, 1'b0, 1, 1'b0};  // cold miss -> way0
        tbl[1] = '{16'h5234, 1'b0, 1'b1, 2, 1'b0};  // same set, way0 valid -> way1
        tbl[2] = '{16'h1234, 1'b1, 1'b0, 1, 1'b0};  // hit way0 -> lru=1
        tbl[3] = '{16'h9234, 1'b0, 1'b1, 1, 1'b0};  // both valid, evict lru way1
        tbl[4] = '{16'h5234, 1'b0, 1'b0, 3, 1'b1};  // lru now 0 -> evict way0
        tbl[5] = '{16'h9234, 1'b1, 1'b1, 1, 1'b0};
        tbl[6] = '{16'h0040, 1'b0, 1'b0, 4, 1'b1};  // latency 4 with gaps

        model_clear_valid();
        for (int i = 0; i < NSETS; i++) m_lru[i] = 1'b0;

        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_addr       = 16'h0000;
        bus.flush          = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = 16'h0000;
        @(negedge clk);
        #1;
        check("rst_hit", bus.hit, 1'b0);
        check("rst_hit_way", bus.hit_way, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 16'h0000);
        check("rst_fill_we", bus.fill_we, 1'b0);
        check("rst_fill_done", bus.fill_done, 1'b0);
        check("rst_fill_set", bus.fill_set, 0);
        check("rst_fill_word", bus.fill_word, 0);
        check("rst_fill_way", bus.fill_way, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            access(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_way, tbl[i].lat, tbl[i].gap, 0);
        end

        // Flush together with a hitting request: valid bits clear, LRU untouched.
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h9234;
        bus.flush     = 1'b1;
        #1;
        check("flush_cycle_hit", bus.hit, 1'b1);
        check("flush_cycle_way", bus.hit_way, 1'b1);
        check("flush_cycle_stall", bus.stall, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        model_clear_valid();
        prior[0] = 16'h5234;
        prior[1] = 16'h9234;
        prior[2] = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = prior[i];
            #1;
            check("post_flush_miss", bus.hit, 1'b0);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);

        // Stray memory returns while idle are ignored.
        for (int i = 0; i < 3; i++) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = 16'($urandom);
            #1;
            check("stray_fill_we", bus.fill_we, 1'b0);
            check("stray_stall", bus.stall, 1'b0);
            check("stray_fill_done", bus.fill_done, 1'b0);
            check("stray_mem_req", bus.mem_req, 1'b0);
            @(negedge clk);
        end
        bus.mem_data_valid = 1'b0;

        // Reset after the third return, then the same address must miss again.
        access(16'h1234, 1'b0, 1'b0, 1, 1'b0, 3);
        @(negedge clk);
        access(16'h1234, 1'b0, 1'b0, 2, 1'b0, 0);

        // Random accesses over a few sets and tags, predicted by the model.
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.flush = 1'b1;
                #1;
                check("rand_flush_stall", bus.stall, 1'b0);
                @(negedge clk);
                bus.flush = 1'b0;
                model_clear_valid();
            end else begin
                sel = $urandom_range(0, 3);
                a[15:10] = 6'($urandom_range(0, 3));
                case (sel)
                    0:       a[9:4] = 6'h00;
                    1:       a[9:4] = 6'h01;
                    2:       a[9:4] = 6'h23;
                    default: a[9:4] = 6'h3F;
                endcase
                a[3:1] = 3'($urandom_range(0, 7));
                a[0]   = 1'b0;
                predict(a, h, w);
                access(a, h, w, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
